alu_sout_decoder: RTL
=====================

# alu_sout_decoder

Serial response decoder for the serial ALU output line `sout`. It deframes the 11-bit packets the ALU transmits and assembles either a result response (4 DATA frames plus 1 CTL frame) or an error response (1 CTL frame). It checks CRC3, parity and framing, then presents one decoded response per `rsp_valid` pulse. It sits beside the DUT in the testbench and feeds the scoreboard. It is the receive-side counterpart of the tester's input-frame generator.

## Interface
- `GAP_TIMEOUT`, default 64: maximum idle cycles allowed between frames of one result response before the response is aborted.
- `clk` input 1: single clock; `sout` is sampled on the rising edge, one bit per cycle.
- `rst_n` input 1: synchronous, active-low reset.
- `sout` input 1: ALU serial output; idles high.
- `rsp_valid` output 1: one-cycle pulse when a response is complete.
- `rsp_is_err` output 1: the response was an error frame.
- `result` output 32: C[31:0], assembled MSB frame first.
- `flags` output 4: {carry, overflow, zero, negative}.
- `crc_rx` output 3: received CRC3 field.
- `crc_ok` output 1: received CRC matches the computed CRC3.
- `err_flags` output 6: {ERR_DATA, ERR_CRC, ERR_OP} sent twice, bits [5:3] then [2:0].
- `parity_ok` output 1: the error-frame payload has even parity.
- `frame_err` output 1: one-cycle pulse on a protocol violation; it is mutually exclusive with `rsp_valid`.

## Operation
- Frame format: start bit 0, type bit (0 for DATA, 1 for CTL), payload[7:0] MSB first, stop bit 1.
- Framing FSM states:
  - IDLE: `sout`=0 moves to SHIFT with the bit counter cleared.
  - SHIFT: captures 10 bits (type, payload, stop). After the stop bit it moves to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE.
- Response sequencer (`frame_idx` 0..4):
  - DATA frame: payload goes into byte `frame_idx` (byte 0 is C[31:24]), then `frame_idx` increments.
  - CTL frame with `frame_idx`=4 and payload[7]=0 completes a result response. Payload[6:3] is `flags` and payload[2:0] is `crc_rx`.
  - CTL frame with `frame_idx`=0 and payload[7]=1 completes an error response. Payload[6:1] is `err_flags`, and `parity_ok` is the XOR-reduce of payload[7:0] equal to 0.
  - Any other combination is a `frame_err`. This covers a DATA frame at `frame_idx`=4, a CTL frame at `frame_idx` 1..3, and payload[7] mismatching `frame_idx`.
- Stop bit 0: `frame_err`, the frame is discarded, `frame_idx` clears and the FSM returns to IDLE.
- CRC3 definition:
  - Polynomial x^3+x+1, LFSR initialised to 0.
  - Message is the 37 bits {C[31:0], 1'b0, flags[3:0]}, MSB first.
  - CRC is the remainder of M(x)·x^3.
  - It is computed serially while bits shift in, or in parallel during CHECK; either is acceptable, but the result must be available at `rsp_valid`.
- Gap timer:
  - Counts IDLE cycles while `frame_idx` is nonzero.
  - Reaching `GAP_TIMEOUT` pulses `frame_err` and clears `frame_idx`.
  - It does not count while `frame_idx`=0.
- `crc_ok` is computed only for result responses; for error responses it is 0. `parity_ok` is 0 for result responses.

## Timing
- Reset values: `rsp_valid`=0, `frame_err`=0, `rsp_is_err`=0, `result`=0, `flags`=0, `crc_rx`=0, `crc_ok`=0, `err_flags`=0, `parity_ok`=0. State is IDLE, `frame_idx`=0, gap timer=0.
- Reset asserted mid-frame aborts the frame with no pulse on either output.
- Latency: `rsp_valid` or `frame_err` rises in the cycle after the stop bit is sampled. With the start bit sampled at cycle t, the pulse appears at t+11.
- Back-to-back frames: a start bit may be sampled on the cycle immediately after the stop bit, which is the CHECK cycle. CHECK must also act as IDLE for start detection, so there are no dead cycles.
- Output data registers hold their value until the next `rsp_valid`; they do not change on `frame_err`.
- Fields that do not apply to the response type are driven to 0 at `rsp_valid`: `flags`, `crc_rx` and `result` for an error response, `err_flags` for a result response.
- No backpressure: every complete response produces exactly one pulse.

## Test plan
- Reset holds `sout`=1; then release `rst_n` -> all outputs 0 and no pulse for 100 cycles.
- Send DATA frames 00,00,00,00 followed by CTL payload 0b0_0010_110 -> `rsp_valid` at t+11 of the CTL start, `result`=0x00000000, `flags`=4'b0010, `crc_rx`=3'b110, `crc_ok`=1.
- Repeat the previous case with CRC field 3'b111 -> `crc_ok`=0, all other fields identical.
- Send a single CTL frame with payload 0x93 (ERR_OP both copies) -> `rsp_is_err`=1, `err_flags`=6'b001001, `parity_ok`=1. The same frame with payload 0x92 -> `parity_ok`=0.
- Send 2 DATA frames, then hold idle for `GAP_TIMEOUT` cycles -> a single `frame_err` pulse. A following valid 5-frame response then decodes correctly.
- Send a frame whose stop bit is 0, followed back-to-back by a valid error frame -> `frame_err` pulse, then `rsp_valid` with `rsp_is_err`=1, with no dropped start bit.

Source files
------------

// File: rtl/alu_sout_decoder.sv
// Deframes 11-bit packets on the ALU serial output and assembles result or error responses.
// Checks CRC3, parity and framing; one rsp_valid or frame_err pulse per completed/broken packet.
module alu_sout_decoder #(
  parameter int GAP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        rsp_valid,
  output logic        rsp_is_err,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [2:0]  crc_rx,
  output logic        crc_ok,
  output logic [5:0]  err_flags,
  output logic        parity_ok,
  output logic        frame_err
);

  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [2:0]    frame_idx;
  logic [31:0]   data_buf;
  logic [GW-1:0] gap_cnt;

  logic       stop_now;
  logic       is_ctl;
  logic [7:0] payload;
  logic       take_data;
  logic       take_rsp;
  logic       take_err;
  logic       bad_frame;
  logic       gap_expired;

  // Remainder of {C, 1'b0, flags} * x^3 modulo x^3+x+1.
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = msg[i] ^ c[2];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  // CHECK doubles as IDLE so a start bit right after a stop bit is not lost.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!sout) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 4'd9) state_next = CHECK;
      CHECK:   state_next = sout ? IDLE : SHIFT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stop_now    = (state == SHIFT) && (bit_cnt == 4'd9);
    is_ctl      = shreg[8];
    payload     = shreg[7:0];
    take_data   = 1'b0;
    take_rsp    = 1'b0;
    take_err    = 1'b0;
    bad_frame   = 1'b0;
    gap_expired = (state == IDLE) && (frame_idx != 3'd0) && sout && (gap_cnt == GAP_LAST);
    if (stop_now) begin
      if (!sout) begin
        bad_frame = 1'b1;
      end else if (!is_ctl) begin
        if (frame_idx < 3'd4) take_data = 1'b1;
        else                  bad_frame = 1'b1;
      end else if ((frame_idx == 3'd4) && !payload[7]) begin
        take_rsp = 1'b1;
      end else if ((frame_idx == 3'd0) && payload[7]) begin
        take_err = 1'b1;
      end else begin
        bad_frame = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 9'd0;
      frame_idx  <= 3'd0;
      data_buf   <= 32'd0;
      gap_cnt    <= '0;
      rsp_valid  <= 1'b0;
      frame_err  <= 1'b0;
      rsp_is_err <= 1'b0;
      result     <= 32'd0;
      flags      <= 4'd0;
      crc_rx     <= 3'd0;
      crc_ok     <= 1'b0;
      err_flags  <= 6'd0;
      parity_ok  <= 1'b0;
    end else begin
      state     <= state_next;
      rsp_valid <= take_rsp | take_err;
      frame_err <= bad_frame | gap_expired;

      if (state == SHIFT) begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {shreg[7:0], sout};
      end else begin
        bit_cnt <= 4'd0;
      end

      if ((state == IDLE) && (frame_idx != 3'd0) && !gap_expired) gap_cnt <= gap_cnt + 1'b1;
      else                                                       gap_cnt <= '0;

      if (bad_frame || gap_expired || take_rsp) frame_idx <= 3'd0;
      else if (take_data)                       frame_idx <= frame_idx + 3'd1;

      if (take_data) begin
        case (frame_idx[1:0])
          2'd0:    data_buf[31:24] <= payload;
          2'd1:    data_buf[23:16] <= payload;
          2'd2:    data_buf[15:8]  <= payload;
          default: data_buf[7:0]   <= payload;
        endcase
      end

      if (take_rsp) begin
        rsp_is_err <= 1'b0;
        result     <= data_buf;
        flags      <= payload[6:3];
        crc_rx     <= payload[2:0];
        crc_ok     <= (crc3({data_buf, 1'b0, payload[6:3]}) == payload[2:0]);
        err_flags  <= 6'd0;
        parity_ok  <= 1'b0;
      end else if (take_err) begin
        rsp_is_err <= 1'b1;
        result     <= 32'd0;
        flags      <= 4'd0;
        crc_rx     <= 3'd0;
        crc_ok     <= 1'b0;
        err_flags  <= payload[6:1];
        parity_ok  <= ~^payload;
      end
    end
  end

endmodule
